// File: rtl/ptp_bridge_avmm_rsp_gen.sv
// ---------------------------------------------------------------------------
// ptp_bridge_avmm_rsp_gen
//
// Builds the Avalon-MM read-response stream returned to the master. Every
// accepted read is classified as hit or miss against the address window
// [BASE_ADDR, BASE_ADDR+MAX_ADDR]. The hit/miss tag is queued in accept
// order. A miss is answered locally with ERR_DATA. A hit is answered with
// the next downstream response. Responses therefore leave in accept order.
//
// Optional build macro:
//   PTP_BRIDGE_AVMM_RSP_TIMEOUT_EN - adds a response timer. A hit that waits
//   TIMEOUT_CYCLES cycles is answered with ERR_DATA. Its late downstream
//   response is discarded when it arrives.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   igr_avmm_address/read/write  master request (writes get no response)
//   slv_avmm_readdata/valid   downstream read responses
//   egr_avmm_waitrequest      master stall (tracking FIFO full)
//   egr_avmm_readdata/valid   registered responses to the master
//   err_cnt                   saturating count of ERR_DATA responses
// ---------------------------------------------------------------------------
module ptp_bridge_avmm_rsp_gen #(
  parameter BASE_ADDR       = 'h0,
  parameter MAX_ADDR        = 'h8,
  parameter ADDR_WIDTH      = 8,
  parameter DATA_WIDTH      = 32,
  parameter MAX_OUTSTANDING = 4,
  parameter ERR_DATA        = 'hDEAD_BEEF,
  parameter TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] igr_avmm_address,
  input  logic                  igr_avmm_read,
  input  logic                  igr_avmm_write,
  input  logic [DATA_WIDTH-1:0] slv_avmm_readdata,
  input  logic                  slv_avmm_readdatavalid,
  output logic                  egr_avmm_waitrequest,
  output logic [DATA_WIDTH-1:0] egr_avmm_readdata,
  output logic                  egr_avmm_readdatavalid,
  output logic [15:0]           err_cnt
);

  localparam int PW = (MAX_OUTSTANDING > 2) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;

  // Writes are accepted upstream but never generate a response here.
  logic unused_write;
  assign unused_write = igr_avmm_write;

  // Order FIFO (1 = miss) and data FIFO state.
  logic                  ord_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         ord_wr_reg, ord_rd_reg;
  logic [CW-1:0]         ord_cnt_reg, ord_cnt_next;
  logic [DATA_WIDTH-1:0] dat_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         dat_wr_reg, dat_rd_reg;
  logic [CW-1:0]         dat_cnt_reg, dat_cnt_next;

  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [15:0]           err_cnt_reg;

  // Range check. The extra MSB of adj is the borrow of the subtraction.
  logic [ADDR_WIDTH:0] adj;
  logic                miss;
  assign adj  = {1'b0, igr_avmm_address} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
  assign miss = adj[ADDR_WIDTH] | (adj[ADDR_WIDTH-1:0] > ADDR_WIDTH'(MAX_ADDR));

  logic accept, ord_nonempty, dat_nonempty, head_miss, drop_active, arrive;
  logic pop_miss, pop_hit, pop_to, pop_ord, bypass, dat_push, dat_pop, emit_err;

  assign egr_avmm_waitrequest = (ord_cnt_reg == CW'(MAX_OUTSTANDING));
  assign accept       = igr_avmm_read & ~egr_avmm_waitrequest;
  assign ord_nonempty = (ord_cnt_reg != '0);
  assign dat_nonempty = (dat_cnt_reg != '0);
  assign head_miss    = ord_mem[ord_rd_reg];

`ifdef PTP_BRIDGE_AVMM_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_reg;
  logic [7:0]    drop_cnt_reg;
  logic          discard;

  assign drop_active = (drop_cnt_reg != '0);
  assign discard     = slv_avmm_readdatavalid & drop_active;
  // Expiry is checked only when no usable data arrives this cycle, so a
  // response in the expiry cycle wins over the timeout.
  assign pop_to = ord_nonempty & ~head_miss & ~dat_nonempty & ~arrive &
                  (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (pop_ord)
        timer_reg <= '0;
      else if (ord_nonempty & ~head_miss & ~dat_nonempty)
        timer_reg <= timer_reg + TW'(1);
      if (pop_to & ~discard) begin
        if (drop_cnt_reg != 8'hFF)
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end else if (discard & ~pop_to) begin
        drop_cnt_reg <= drop_cnt_reg - 8'd1;
      end
    end
  end
`else
  assign drop_active = 1'b0;
  assign pop_to      = 1'b0;
`endif

  assign arrive   = slv_avmm_readdatavalid & ~drop_active;
  assign pop_miss = ord_nonempty & head_miss;
  // A hit at the head may take the response straight off the downstream
  // bus, which gives the one-cycle hit latency.
  assign pop_hit  = ord_nonempty & ~head_miss & (dat_nonempty | arrive);
  assign bypass   = pop_hit & ~dat_nonempty;
  assign pop_ord  = pop_miss | pop_hit | pop_to;
  assign emit_err = pop_miss | pop_to;
  assign dat_push = arrive & ~bypass;
  assign dat_pop  = pop_hit & dat_nonempty;

  always_comb begin
    ord_cnt_next = ord_cnt_reg;
    dat_cnt_next = dat_cnt_reg;
    if (accept & ~pop_ord)
      ord_cnt_next = ord_cnt_reg + CW'(1);
    else if (~accept & pop_ord)
      ord_cnt_next = ord_cnt_reg - CW'(1);
    if (dat_push & ~dat_pop)
      dat_cnt_next = dat_cnt_reg + CW'(1);
    else if (~dat_push & dat_pop)
      dat_cnt_next = dat_cnt_reg - CW'(1);
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (accept)
      ord_mem[ord_wr_reg] <= miss;
    if (dat_push)
      dat_mem[dat_wr_reg] <= slv_avmm_readdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_wr_reg    <= '0;
      ord_rd_reg    <= '0;
      ord_cnt_reg   <= '0;
      dat_wr_reg    <= '0;
      dat_rd_reg    <= '0;
      dat_cnt_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      ord_cnt_reg <= ord_cnt_next;
      dat_cnt_reg <= dat_cnt_next;
      if (accept)   ord_wr_reg <= ord_wr_reg + PW'(1);
      if (pop_ord)  ord_rd_reg <= ord_rd_reg + PW'(1);
      if (dat_push) dat_wr_reg <= dat_wr_reg + PW'(1);
      if (dat_pop)  dat_rd_reg <= dat_rd_reg + PW'(1);

      rsp_valid_reg <= pop_ord;
      if (emit_err)
        rsp_data_reg <= DATA_WIDTH'(ERR_DATA);
      else if (pop_hit)
        rsp_data_reg <= bypass ? slv_avmm_readdata : dat_mem[dat_rd_reg];

      if (emit_err && err_cnt_reg != 16'hFFFF)
        err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign egr_avmm_readdatavalid = rsp_valid_reg;
  assign egr_avmm_readdata      = rsp_data_reg;
  assign err_cnt                = err_cnt_reg;

endmodule
